// File: rtl/pool2_flatten_reader.sv
// Captures pooled layer-2 rows into a CH x ROWS x COLS frame store and replays it as a
// flattened word stream. Define POOL2_PINGPONG_EN for two alternating banks (default: one bank).
module pool2_flatten_reader #(
  parameter int unsigned DW   = 16,
  parameter int unsigned COLS = 7,
  parameter int unsigned ROWS = 7,
  parameter int unsigned CH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           in_ch,
  input  logic [COLS*DW-1:0]   in_row,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 frame_done,
  output logic                 overflow
);

`ifdef POOL2_PINGPONG_EN
  localparam int unsigned NBANK = 2;
`else
  localparam int unsigned NBANK = 1;
`endif
  localparam int unsigned DEPTH = CH * ROWS * COLS;
  localparam int unsigned AW    = $clog2(NBANK * DEPTH);
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned RW    = $clog2(ROWS + 1);
  localparam int unsigned CW    = 2;
  localparam int unsigned NCH   = 1 << CW;
  localparam logic [NCH-1:0] CH_MASK = NCH'((64'd1 << CH) - 64'd1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t          state, state_d;
  logic [DW-1:0]   mem [NBANK*DEPTH];
  logic [RW-1:0]   wr_row [NCH];
  logic [1:0]      bank_busy, bank_busy_d;
  logic            wr_bank, rd_bank, rd_bank_d;
  logic [IW-1:0]   rd_idx, rd_idx_d, rd_idx_nxt_c;
  logic [DW-1:0]   out_data_d;
  logic            out_valid_d, out_last_d;
  logic            others_full_c, accept_c, complete_c, drop_c, avail_c, release_c;
  logic [AW-1:0]   wr_base_c;

  function automatic logic [AW-1:0] rd_addr(input logic bank, input logic [IW-1:0] idx);
    return AW'(32'(bank) * DEPTH + 32'(idx));
  endfunction

  // Write admission: row slot free, channel legal, target bank neither full nor streaming
  always_comb begin
    others_full_c = 1'b1;
    for (int c = 0; c < int'(CH); c++) begin
      if (CW'(c) != in_ch && wr_row[CW'(c)] != RW'(ROWS)) others_full_c = 1'b0;
    end
    accept_c   = in_valid && CH_MASK[in_ch] && (wr_row[in_ch] != RW'(ROWS)) && !bank_busy[wr_bank];
    complete_c = accept_c && (wr_row[in_ch] == RW'(ROWS - 1)) && others_full_c;
    drop_c     = in_valid && !accept_c;
    avail_c    = bank_busy[rd_bank] || (complete_c && (wr_bank == rd_bank));
    wr_base_c  = AW'(32'(wr_bank) * DEPTH + 32'(in_ch) * ROWS * COLS + 32'(wr_row[in_ch]) * COLS);
  end

  always_comb begin
    bank_busy_d = bank_busy;
    if (release_c)  bank_busy_d[rd_bank] = 1'b0;
    if (complete_c) bank_busy_d[wr_bank] = 1'b1;
  end

  // Frame store: no reset, contents are only trusted once a bank is marked full
  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int j = 0; j < int'(COLS); j++) begin
        mem[wr_base_c + AW'(j)] <= in_row[j*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(NCH); c++) wr_row[c] <= '0;
      wr_bank   <= 1'b0;
      bank_busy <= '0;
      overflow  <= 1'b0;
    end else begin
      if (drop_c) overflow <= 1'b1;
      if (complete_c) begin
        for (int c = 0; c < int'(NCH); c++) wr_row[c] <= '0;
`ifdef POOL2_PINGPONG_EN
        wr_bank <= ~wr_bank;
`endif
      end else if (accept_c) begin
        wr_row[in_ch] <= wr_row[in_ch] + RW'(1);
      end
      bank_busy <= bank_busy_d;
    end
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_idx     <= '0;
      rd_bank    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      rd_idx     <= rd_idx_d;
      rd_bank    <= rd_bank_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      out_last   <= out_last_d;
      frame_done <= (state_d == DONE);
    end
  end

  // Read FSM next state; outputs advance only on a handshake so stalls hold them
  always_comb begin
    state_d      = state;
    rd_idx_d     = rd_idx;
    rd_bank_d    = rd_bank;
    out_data_d   = out_data;
    out_valid_d  = out_valid;
    out_last_d   = out_last;
    release_c    = 1'b0;
    rd_idx_nxt_c = rd_idx + IW'(1);
    case (state)
      STREAM: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            release_c   = 1'b1;
`ifdef POOL2_PINGPONG_EN
            rd_bank_d   = ~rd_bank;
`endif
          end else begin
            rd_idx_d   = rd_idx_nxt_c;
            out_data_d = mem[rd_addr(rd_bank, rd_idx_nxt_c)];
            out_last_d = (rd_idx_nxt_c == IW'(DEPTH - 1));
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (avail_c) begin
          state_d     = STREAM;
          rd_idx_d    = '0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          out_data_d  = mem[rd_addr(rd_bank, '0)];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pool2_flatten_reader.sv
// Scoreboard bench for pool2_flatten_reader: stimulus pushes expected words, a monitor pops them.
module tb_pool2_flatten_reader;
  localparam int unsigned DW = 16, COLS = 7, ROWS = 7, CH = 4, DEPTH = 196;

  logic                clk = 1'b0;
  logic                rst, in_valid, out_ready;
  logic [1:0]          in_ch;
  logic [COLS*DW-1:0]  in_row;
  logic [DW-1:0]       out_data;
  logic                out_valid, out_last, frame_done, overflow;

  typedef struct packed { logic [15:0] data; logic last; } exp_t;
  exp_t sb_q[$];
  int checks = 0, errors = 0, cyc = 0, first_valid_cyc = 0, last_hs_cyc = 0;

  pool2_flatten_reader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_row(in_row),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected words on handshakes and checks stability during stalls
  initial begin : monitor
    logic pv, ps, pl;
    logic [15:0] pd;
    exp_t e;
    pv = 1'b0; ps = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; ps = 1'b0;
      end else begin
        if (ps) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_data", int'(out_data), int'(pd));
          check("stall_last", int'(out_last), int'(pl));
        end
        if (out_valid && !pv) first_valid_cyc = cyc;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word actual=%0d required=none", out_data);
          end else begin
            e = sb_q.pop_front();
            check("word_data", int'(out_data), int'(e.data));
            check("word_last", int'(out_last), int'(e.last));
          end
          last_hs_cyc = cyc;
        end
        pv = out_valid; ps = out_valid && !out_ready; pd = out_data; pl = out_last;
      end
    end
  end

  task automatic write_row(input int ch, input int row, input int off);
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    for (int j = 0; j < int'(COLS); j++) in_row[j*DW +: DW] = 16'(off + ch*49 + row*7 + j);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_frame(input int off, input bit skip_first);
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(CH); c++)
        if (!(skip_first && r == 0 && c == 0)) write_row(c, r, off);
  endtask

  task automatic push_frame(input int off);
    for (int k = 0; k < int'(DEPTH); k++) sb_q.push_back('{16'(off + k), (k == int'(DEPTH) - 1)});
  endtask

  task automatic wait_done(output int dcyc);
    bit seen;
    seen = 1'b0; dcyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (frame_done) begin seen = 1'b1; dcyc = cyc; break; end
    end
    check("frame_done_seen", int'(seen), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : stim
    int d1, d2;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_row = '0; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overflow", int'(overflow), 0);
    @(posedge clk); #1; rst = 1'b0;

    // Full-throughput frame
    out_ready = 1'b1;
    push_frame(0);
    load_frame(0, 1'b0);
    @(negedge clk);
    check("a_first_valid", int'(out_valid), 1);
    check("a_first_data", int'(out_data), 0);
    wait_done(d1);
    check("a_span", last_hs_cyc - first_valid_cyc + 1, 196);
    check("a_done_latency", d1, last_hs_cyc + 1);
    check("a_overflow", int'(overflow), 0);
    check("a_sb_empty", sb_q.size(), 0);
    @(negedge clk);
    check("a_done_pulse", int'(frame_done), 0);

    // Ready toggling every cycle
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_frame(0);
    load_frame(0, 1'b0);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    check("b_done_seen", int'(seen), 1);
    check("b_span", last_hs_cyc - first_valid_cyc + 1, 391);
    check("b_sb_empty", sb_q.size(), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Eighth row on channel 2 is dropped
    check("c_overflow_before", int'(overflow), 0);
    push_frame(0);
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(CH); c++) begin
        write_row(c, r, 0);
        if (r == int'(ROWS) - 1 && c == 2) begin
          write_row(2, 0, 5000);
          @(negedge clk);
          check("c_overflow_after", int'(overflow), 1);
        end
      end
    wait_done(d1);
    check("c_sb_empty", sb_q.size(), 0);
    check("c_overflow_sticky", int'(overflow), 1);
    do_reset();
    @(negedge clk);
    check("c_overflow_cleared", int'(overflow), 0);
    @(posedge clk); #1;

`ifdef POOL2_PINGPONG_EN
    // Second frame written while the first streams
    push_frame(0);
    push_frame(1000);
    load_frame(0, 1'b0);
    load_frame(1000, 1'b0);
    wait_done(d1);
    @(negedge clk);
    check("d_b2b_valid", int'(out_valid), 1);
    check("d_b2b_data", int'(out_data), 1000);
    wait_done(d2);
    check("d_b2b_spacing", d2 - d1, 197);
    check("d_overflow", int'(overflow), 0);
    check("d_sb_empty", sb_q.size(), 0);
`else
    // Write during streaming is dropped; write in the frame_done cycle is accepted
    push_frame(0);
    push_frame(0);
    load_frame(0, 1'b0);
    write_row(1, 0, 5000);
    @(negedge clk);
    check("d_drop_overflow", int'(overflow), 1);
    wait_done(d1);
    write_row(0, 0, 0);
    load_frame(0, 1'b1);
    wait_done(d2);
    check("d_sb_empty", sb_q.size(), 0);
    check("d_overflow_sticky", int'(overflow), 1);
`endif

    // Reset at word 100
    @(posedge clk); #1;
    push_frame(2000);
    load_frame(2000, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("e_words_left", sb_q.size(), 96);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("e_out_valid", int'(out_valid), 0);
    check("e_out_data", int'(out_data), 0);
    check("e_out_last", int'(out_last), 0);
    check("e_overflow", int'(overflow), 0);
    @(posedge clk); #1;
    push_frame(3000);
    load_frame(3000, 1'b0);
    @(negedge clk);
    check("e_fresh_first", int'(out_data), 3000);
    wait_done(d1);
    check("e_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool2_flatten_reader.md
# pool2_flatten_reader

Reader for the second pooling stage: captures the 7-value pooled rows produced per feature-map channel, stores a full 4×7×7 frame, and replays it as a flattened stream of single 16-bit words to the fully-connected layer. Sits between the layer-2 pooling stage and the FC input, with a valid/ready handshake on the output side.

## Interface
- DW, 16, width of one fixed-point value
- COLS, 7, values per pooled row
- ROWS, 7, pooled rows per channel
- CH, 4, channels per frame
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  pooled row present this cycle
- in_ch  in  2  channel index of the row (0..CH-1)
- in_row  in  COLS*DW (112)  pooled row; col j = in_row[j*DW+DW-1 : j*DW]
- out_data  out  DW  flattened word
- out_valid  out  1  out_data valid
- out_ready  in  1  FC layer accepts word
- out_last  out  1  high with word CH*ROWS*COLS-1 (195)
- frame_done  out  1  one-cycle pulse after last word accepted
- overflow  out  1  sticky: a row was dropped

## Operation
- Storage: bank of CH*ROWS*COLS = 196 words; address = ch*49 + row*7 + col.
- Write side: per-channel row counter wr_row[ch] (0..7). Accepted write of in_row for channel c stores all 7 columns at row wr_row[c], then wr_row[c]++.
- Write dropped, overflow set, when: wr_row[in_ch] == ROWS, or target bank is not free (full or being read). Dropped writes change no counter.
- Bank full when all wr_row[] == ROWS; counters clear when bank is handed to read side.
- Read FSM: IDLE -> STREAM when a full bank is available; STREAM -> DONE when handshake (out_valid & out_ready) occurs with out_last; DONE -> IDLE (or STREAM if another full bank waits) after one cycle.
- Read order: channel-major, then row, then column (index 0..195).
- out_data/out_valid/out_last held stable while out_valid & !out_ready.
- frame_done = 1 exactly in DONE.
- overflow cleared only by rst.
- Values are passed unaltered; no arithmetic on data.

## Timing
- Reset values: out_data 0, out_valid 0, out_last 0, frame_done 0, overflow 0, all wr_row 0, FSM IDLE, all banks free.
- Write completing the frame in cycle N: out_valid=1 with word 0 in cycle N+1.
- Full-throughput: 196 words in 196 consecutive cycles when out_ready held high; word k+1 presented the cycle after word k handshakes.
- Last handshake in cycle M: frame_done=1 in cycle M+1; bank free from cycle M+1 (writes in cycle M+1 accepted, writes in cycle M dropped in single-bank mode).
- overflow asserts the cycle after the dropped write.
- rst mid-stream: stream aborted, stored data discarded, outputs return to reset values next cycle.
- in_ch ≥ CH impossible at CH=4; for smaller CH treated as dropped write + overflow.

## Configuration
- POOL2_PINGPONG_EN defined: two banks; write side fills bank B while bank A streams; banks alternate; frame k+1 streams starting the cycle after DONE of frame k if already full; overflow only when both banks are full/reading.
- Undefined: one bank; all writes between frame-full and frame_done are dropped with overflow.

## Test plan
- Load 28 rows (ch 0..3 interleaved per row, value = ch*49+row*7+col), out_ready=1 -> out_data 0,1,…,195 on consecutive cycles, out_last on 195, frame_done pulse next cycle, overflow 0.
- Same frame, out_ready toggling 1/0 each cycle -> same sequence, data held during stalls, 391 cycles from first out_valid to last handshake.
- Send an 8th row for ch 2 before frame completes -> row dropped, overflow=1 next cycle, frame still streams correctly.
- Single-bank build: send a new row during streaming -> dropped, overflow=1; row sent the cycle after frame_done -> accepted. Pingpong build: second frame written during streaming -> streams back-to-back, overflow 0.
- Assert rst at word 100 -> out_valid=0, overflow=0 next cycle; fresh frame afterwards streams from word 0.
